minitb_apb_cmd_master: RTL and testbench

//  Parametrised, synthesisable APB master for miniTB benches and RTL fabrics: accepts

---
 rtl/minitb_apb_cmd_master_pkg.sv | 21 ++
 rtl/minitb_sync_fifo.sv | 62 ++++++
 rtl/minitb_apb_cmd_master.sv | 164 ++++++++++++++++
 tb/tb_minitb_apb_cmd_master.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/minitb_apb_cmd_master_pkg.sv
// Shared types for the miniTB APB command master: FSM states, response codes
// and a width helper for parameter-derived vectors.
package minitb_apb_pkg;

   typedef enum logic [1:0] {
      APB_IDLE,
      APB_SETUP,
      APB_ACCESS
   } apb_state_e;

   typedef enum logic [1:0] {
      RSP_OK      = 2'b00,
      RSP_SLVERR  = 2'b01,
      RSP_TIMEOUT = 2'b10
   } apb_rsp_e;

   function automatic int unsigned clog2_min1(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/minitb_sync_fifo.sv
// Synchronous FIFO for completed APB responses; read data is the head entry,
// a push becomes visible the cycle after it is written.
module minitb_sync_fifo
   import minitb_apb_pkg::*;
#(
   parameter int unsigned WIDTH = 34,
   parameter int unsigned DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             empty
);

   localparam int unsigned AW = clog2_min1(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic             full, do_push, do_pop;

   always_comb begin
      full     = (cnt_q == CW'(DEPTH));
      empty    = (cnt_q == '0);
      do_pop   = pop && !empty;
      // a push into a full FIFO is legal only when the head leaves the same cycle
      do_push  = push && (!full || do_pop);
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = wdata;
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
   end

   assign rdata = mem_q[rd_ptr_q];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
      mem_q <= mem_d;
   end

endmodule

// File: rtl/minitb_apb_cmd_master.sv
// APB master: valid/ready command port, IDLE/SETUP/ACCESS sequencing with wait
// states, slave error and timeout, in-order responses through a credited FIFO.
module minitb_apb_cmd_master
   import minitb_apb_pkg::*;
#(
   parameter int unsigned ADDR_W    = 8,
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned NUM_SLV   = 1,
   parameter int unsigned RSP_DEPTH = 2,
   parameter int unsigned TMO_CYC   = 16
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             cmd_valid,
   output logic                             cmd_ready,
   input  logic                             cmd_write,
   input  logic [ADDR_W-1:0]                cmd_addr,
   input  logic [DATA_W-1:0]                cmd_wdata,
   input  logic [DATA_W/8-1:0]              cmd_strb,
   input  logic [clog2_min1(NUM_SLV)-1:0]   cmd_slv,
   output logic                             rsp_valid,
   input  logic                             rsp_ready,
   output logic [DATA_W-1:0]                rsp_rdata,
   output logic [1:0]                       rsp_code,
   output logic [ADDR_W-1:0]                paddr,
   output logic                             pwrite,
   output logic [NUM_SLV-1:0]               psel,
   output logic                             penable,
   output logic [DATA_W-1:0]                pwdata,
   output logic [DATA_W/8-1:0]              pstrb,
   input  logic [DATA_W-1:0]                prdata,
   input  logic                             pready,
   input  logic                             pslverr
);

   localparam int unsigned STRB_W = DATA_W / 8;
   localparam int unsigned CW     = $clog2(RSP_DEPTH + 1);
   localparam int unsigned TW     = clog2_min1(TMO_CYC);
   localparam logic [TW-1:0] TMO_LAST = TW'((TMO_CYC > 0) ? TMO_CYC - 1 : 0);

   apb_state_e          state_q, state_d;
   logic [ADDR_W-1:0]   paddr_q, paddr_d;
   logic                pwrite_q, pwrite_d;
   logic [NUM_SLV-1:0]  psel_q, psel_d;
   logic                penable_q, penable_d;
   logic [DATA_W-1:0]   pwdata_q, pwdata_d;
   logic [STRB_W-1:0]   pstrb_q, pstrb_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [TW-1:0]       tmr_q, tmr_d;

   logic                done, tmo, accept, pop, fifo_empty;
   apb_rsp_e            code_in;
   logic [DATA_W-1:0]   rdata_in;
   logic [DATA_W+1:0]   fifo_rdata;

   always_comb begin
      state_d   = state_q;
      paddr_d   = paddr_q;
      pwrite_d  = pwrite_q;
      psel_d    = psel_q;
      penable_d = penable_q;
      pwdata_d  = pwdata_q;
      pstrb_d   = pstrb_q;
      tmr_d     = tmr_q;
      tmo       = 1'b0;
      done      = 1'b0;
      if (state_q == APB_ACCESS) begin
         tmo  = (TMO_CYC != 0) && !pready && (tmr_q == TMO_LAST);
         done = pready || tmo;
      end

      // credits: one in flight plus FIFO occupancy; a pop this cycle frees a slot now
      pop       = rsp_valid && rsp_ready;
      cmd_ready = ((state_q == APB_IDLE) || done) && ((cnt_q - CW'(pop)) < CW'(RSP_DEPTH));
      accept    = cmd_valid && cmd_ready;
      cnt_d     = cnt_q + CW'(accept) - CW'(pop);

      if (tmo)          code_in = RSP_TIMEOUT;
      else if (pslverr) code_in = RSP_SLVERR;
      else              code_in = RSP_OK;
      rdata_in = (pwrite_q || tmo) ? '0 : prdata;

      case (state_q)
         APB_SETUP: begin
            state_d   = APB_ACCESS;
            penable_d = 1'b1;
            tmr_d     = '0;
         end
         APB_ACCESS: begin
            if (!done) begin
               if (!pready && (TMO_CYC != 0)) tmr_d = tmr_q + TW'(1);
            end else begin
               state_d   = APB_IDLE;
               psel_d    = '0;
               penable_d = 1'b0;
               paddr_d   = '0;
               pwrite_d  = 1'b0;
               pwdata_d  = '0;
               pstrb_d   = '0;
            end
         end
         default: ;
      endcase

      // an accept in ACCESS overrides the return to IDLE so transfers chain directly
      if (accept) begin
         state_d   = APB_SETUP;
         psel_d    = NUM_SLV'(1) << cmd_slv;
         penable_d = 1'b0;
         paddr_d   = cmd_addr;
         pwrite_d  = cmd_write;
         pwdata_d  = cmd_wdata;
         pstrb_d   = cmd_write ? cmd_strb : '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= APB_IDLE;
         paddr_q   <= '0;
         pwrite_q  <= 1'b0;
         psel_q    <= '0;
         penable_q <= 1'b0;
         pwdata_q  <= '0;
         pstrb_q   <= '0;
         cnt_q     <= '0;
         tmr_q     <= '0;
      end else begin
         state_q   <= state_d;
         paddr_q   <= paddr_d;
         pwrite_q  <= pwrite_d;
         psel_q    <= psel_d;
         penable_q <= penable_d;
         pwdata_q  <= pwdata_d;
         pstrb_q   <= pstrb_d;
         cnt_q     <= cnt_d;
         tmr_q     <= tmr_d;
      end
   end

   minitb_sync_fifo #(
      .WIDTH (DATA_W + 2),
      .DEPTH (RSP_DEPTH)
   ) u_rsp_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (done),
      .wdata ({code_in, rdata_in}),
      .pop   (pop),
      .rdata (fifo_rdata),
      .empty (fifo_empty)
   );

   assign rsp_valid = !fifo_empty;
   assign rsp_code  = fifo_rdata[DATA_W+1:DATA_W];
   assign rsp_rdata = fifo_rdata[DATA_W-1:0];
   assign paddr     = paddr_q;
   assign pwrite    = pwrite_q;
   assign psel      = psel_q;
   assign penable   = penable_q;
   assign pwdata    = pwdata_q;
   assign pstrb     = pstrb_q;

endmodule

// File: tb/tb_minitb_apb_cmd_master.sv
// Bench for minitb_apb_cmd_master: queued command driver, scripted APB slave,
// table vectors, directed timing sequences and a randomized run.
module tb_minitb_apb_cmd_master;

   localparam int unsigned AW  = 8;
   localparam int unsigned DW  = 32;
   localparam int unsigned NS  = 2;
   localparam int unsigned RD  = 2;
   localparam int unsigned TMO = 16;

   typedef struct {
      logic        wr;
      logic [7:0]  addr;
      logic [31:0] wdata;
      logic [3:0]  strb;
      logic        sl;
   } cmd_t;

   typedef struct {
      int unsigned waits;
      logic        err;
      logic [31:0] rdata;
   } beh_t;

   typedef struct {
      logic [1:0]  code;
      logic [31:0] rdata;
   } rsp_t;

   typedef struct {
      cmd_t c;
      beh_t b;
      rsp_t e;
   } vec_t;

   logic          clk, rst;
   logic          cmd_valid, cmd_ready, cmd_write;
   logic [AW-1:0] cmd_addr;
   logic [DW-1:0] cmd_wdata;
   logic [3:0]    cmd_strb;
   logic [0:0]    cmd_slv;
   logic          rsp_valid, rsp_ready;
   logic [DW-1:0] rsp_rdata;
   logic [1:0]    rsp_code;
   logic [AW-1:0] paddr;
   logic          pwrite, penable;
   logic [NS-1:0] psel;
   logic [DW-1:0] pwdata, prdata;
   logic [3:0]    pstrb;
   logic          pready, pslverr;

   minitb_apb_cmd_master #(
      .ADDR_W    (AW),
      .DATA_W    (DW),
      .NUM_SLV   (NS),
      .RSP_DEPTH (RD),
      .TMO_CYC   (TMO)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_write (cmd_write),
      .cmd_addr  (cmd_addr),
      .cmd_wdata (cmd_wdata),
      .cmd_strb  (cmd_strb),
      .cmd_slv   (cmd_slv),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .rsp_code  (rsp_code),
      .paddr     (paddr),
      .pwrite    (pwrite),
      .psel      (psel),
      .penable   (penable),
      .pwdata    (pwdata),
      .pstrb     (pstrb),
      .prdata    (prdata),
      .pready    (pready),
      .pslverr   (pslverr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   int unsigned n_chk = 0, n_pass = 0, n_acc = 0;
   int unsigned rr_mode = 0, vprob = 100, acc_cnt = 0;
   bit          prev_acc = 0, prev_setup = 0;
   beh_t        cur;
   cmd_t        cmdq[$];
   beh_t        behq[$];
   beh_t        slvq[$];
   cmd_t        apbq[$];
   rsp_t        expq[$];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
   endtask

   function automatic cmd_t mkcmd(input logic wr, input logic [7:0] a, input logic [31:0] wd,
                                  input logic [3:0] st, input logic sl);
      cmd_t c;
      c.wr = wr; c.addr = a; c.wdata = wd; c.strb = st; c.sl = sl;
      return c;
   endfunction

   function automatic beh_t mkbeh(input int unsigned w, input logic er, input logic [31:0] rd);
      beh_t b;
      b.waits = w; b.err = er; b.rdata = rd;
      return b;
   endfunction

   function automatic rsp_t mkrsp(input logic [1:0] code, input logic [31:0] rd);
      rsp_t r;
      r.code = code; r.rdata = rd;
      return r;
   endfunction

   // Reference: a slave that stays silent for TMO or more ACCESS cycles causes a timeout.
   function automatic rsp_t model(input cmd_t c, input beh_t b);
      if (b.waits >= TMO) return mkrsp(2'b10, 32'h0);
      return mkrsp(b.err ? 2'b01 : 2'b00, c.wr ? 32'h0 : b.rdata);
   endfunction

   task automatic issue(input cmd_t c, input beh_t b, input rsp_t e);
      cmdq.push_back(c);
      behq.push_back(b);
      expq.push_back(e);
   endtask

   task automatic slave_update();
      cmd_t c;
      logic in_acc;
      in_acc = (psel != '0) && penable;
      if (in_acc && !prev_acc) begin
         acc_cnt = 0;
         chk("setup_before_access", prev_setup, 1'b1);
         chk("apb_pending", apbq.size(), 1);
         if (apbq.size() != 0 && slvq.size() != 0) begin
            c   = apbq.pop_front();
            cur = slvq.pop_front();
            chk("psel", psel, c.sl ? 2'b10 : 2'b01);
            chk("paddr", paddr, c.addr);
            chk("pwrite", pwrite, c.wr);
            chk("pwdata", pwdata, c.wdata);
            chk("pstrb", pstrb, c.wr ? c.strb : 4'h0);
         end
      end else if (in_acc) begin
         acc_cnt++;
      end
      if (in_acc) begin
         pready  = (acc_cnt >= cur.waits);
         pslverr = pready ? cur.err : 1'($urandom());
         prdata  = pready ? cur.rdata : $urandom();
      end else begin
         pready  = 1'($urandom());
         pslverr = 1'($urandom());
         prdata  = $urandom();
      end
      prev_acc   = in_acc;
      prev_setup = (psel != '0) && !penable;
   endtask

   task automatic drive();
      if (cmdq.size() != 0 && $urandom_range(0, 99) < vprob) begin
         cmd_valid = 1'b1;
         cmd_write = cmdq[0].wr;
         cmd_addr  = cmdq[0].addr;
         cmd_wdata = cmdq[0].wdata;
         cmd_strb  = cmdq[0].strb;
         cmd_slv   = cmdq[0].sl;
      end else begin
         cmd_valid = 1'b0;
         cmd_write = 1'($urandom());
         cmd_addr  = 8'($urandom());
         cmd_wdata = $urandom();
         cmd_strb  = 4'($urandom());
         cmd_slv   = 1'($urandom());
      end
      if (rr_mode == 0)      rsp_ready = 1'b1;
      else if (rr_mode == 1) rsp_ready = 1'b0;
      else                   rsp_ready = 1'($urandom());
   endtask

   task automatic tick();
      rsp_t e;
      @(negedge clk);
      if (!rst) begin
         if (rsp_valid && rsp_ready) begin
            chk("rsp_pending", expq.size() != 0, 1'b1);
            if (expq.size() != 0) begin
               e = expq.pop_front();
               chk("rsp_code", rsp_code, e.code);
               chk("rsp_rdata", rsp_rdata, e.rdata);
            end
         end
         if (cmd_valid && cmd_ready) begin
            apbq.push_back(cmdq.pop_front());
            slvq.push_back(behq.pop_front());
            n_acc++;
         end
      end
      @(posedge clk);
      #1;
      slave_update();
      drive();
      #1;
   endtask

   task automatic drain(input int unsigned budget);
      int unsigned n = 0;
      while ((cmdq.size() != 0 || expq.size() != 0) && n < budget) begin
         tick();
         n++;
      end
      chk("drain", (cmdq.size() == 0 && expq.size() == 0), 1'b1);
   endtask

   vec_t tbl[8];

   initial begin
      int unsigned a0, hi, rises, pen;
      bit          last;
      cmd_t        c;
      beh_t        b;

      rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
      cmd_strb = '0; cmd_slv = '0; rsp_ready = 1'b1; prdata = '0; pready = 1'b0; pslverr = 1'b0;

      tbl[0] = '{mkcmd(1'b1, 8'h10, 32'hDEADBEEF, 4'hF, 1'b0), mkbeh(0,  1'b0, 32'h0),        mkrsp(2'b00, 32'h0)};
      tbl[1] = '{mkcmd(1'b0, 8'h24, 32'h0,        4'hF, 1'b0), mkbeh(3,  1'b0, 32'h12345678), mkrsp(2'b00, 32'h12345678)};
      tbl[2] = '{mkcmd(1'b0, 8'h30, 32'h11111111, 4'h3, 1'b1), mkbeh(1,  1'b1, 32'hCAFE0001), mkrsp(2'b01, 32'hCAFE0001)};
      tbl[3] = '{mkcmd(1'b1, 8'h44, 32'h55AA55AA, 4'h6, 1'b0), mkbeh(2,  1'b1, 32'h77777777), mkrsp(2'b01, 32'h0)};
      tbl[4] = '{mkcmd(1'b0, 8'h50, 32'h0,        4'h0, 1'b1), mkbeh(15, 1'b0, 32'hA5A5A5A5), mkrsp(2'b00, 32'hA5A5A5A5)};
      tbl[5] = '{mkcmd(1'b0, 8'h54, 32'h0,        4'h0, 1'b0), mkbeh(16, 1'b0, 32'hFFFF0000), mkrsp(2'b10, 32'h0)};
      tbl[6] = '{mkcmd(1'b1, 8'hFF, 32'h01020304, 4'h5, 1'b1), mkbeh(40, 1'b1, 32'h0),        mkrsp(2'b10, 32'h0)};
      tbl[7] = '{mkcmd(1'b0, 8'h00, 32'h0,        4'h0, 1'b0), mkbeh(0,  1'b0, 32'h0BADF00D), mkrsp(2'b00, 32'h0BADF00D)};

      for (int unsigned i = 0; i < 3; i++) tick();
      rst = 1'b0;
      tick();
      chk("rst_psel", psel, 2'b00);
      chk("rst_penable", penable, 1'b0);
      chk("rst_paddr", paddr, 8'h0);
      chk("rst_pwrite", pwrite, 1'b0);
      chk("rst_pwdata", pwdata, 32'h0);
      chk("rst_pstrb", pstrb, 4'h0);
      chk("rst_rsp_valid", rsp_valid, 1'b0);
      chk("rst_cmd_ready", cmd_ready, 1'b1);

      // single zero-wait write: SETUP, ACCESS, response three cycles after accept
      issue(tbl[0].c, tbl[0].b, tbl[0].e);
      tick();
      chk("t1_cmd_ready", cmd_ready, 1'b1);
      tick();
      chk("t1_setup_psel", psel, 2'b01);
      chk("t1_setup_penable", penable, 1'b0);
      chk("t1_setup_paddr", paddr, 8'h10);
      tick();
      chk("t1_access_penable", penable, 1'b1);
      chk("t1_access_pwdata", pwdata, 32'hDEADBEEF);
      tick();
      chk("t1_rsp_valid", rsp_valid, 1'b1);
      chk("t1_rsp_code", rsp_code, 2'b00);
      chk("t1_idle_psel", psel, 2'b00);
      chk("t1_idle_paddr", paddr, 8'h0);
      chk("t1_idle_pwdata", pwdata, 32'h0);
      drain(10);

      // read with three wait states holds penable for four cycles
      issue(tbl[1].c, tbl[1].b, tbl[1].e);
      pen = 0;
      for (int unsigned i = 0; i < 30 && expq.size() != 0; i++) begin
         tick();
         if (penable) pen++;
      end
      chk("t2_penable_cycles", pen, 4);
      drain(10);

      // four streamed writes keep psel high for eight consecutive cycles
      a0 = n_acc;
      for (int unsigned i = 0; i < 4; i++)
         issue(mkcmd(1'b1, 8'(8'h60 + 4 * i), 32'hA0000000 + i, 4'hF, 1'(i)), mkbeh(0, 1'b0, 32'h0), mkrsp(2'b00, 32'h0));
      tick();
      hi = 0; rises = 0; last = 0;
      for (int unsigned i = 0; i < 12; i++) begin
         tick();
         if (psel != '0) hi++;
         if (psel != '0 && !last) rises++;
         last = (psel != '0);
      end
      chk("t3_psel_cycles", hi, 8);
      chk("t3_psel_rises", rises, 1);
      chk("t3_accepts", n_acc - a0, 4);
      drain(20);

      // responses held back: only RSP_DEPTH commands may be outstanding
      rr_mode = 1;
      a0 = n_acc;
      for (int unsigned i = 0; i < 3; i++)
         issue(mkcmd(1'b1, 8'(8'h80 + i), 32'hB0 + i, 4'h1, 1'b0), mkbeh(0, 1'b0, 32'h0), mkrsp(2'b00, 32'h0));
      for (int unsigned i = 0; i < 12; i++) tick();
      chk("t4_accepts_blocked", n_acc - a0, 2);
      chk("t4_cmd_ready_low", cmd_ready, 1'b0);
      chk("t4_rsp_valid", rsp_valid, 1'b1);
      rr_mode = 0;
      drain(30);
      chk("t4_accepts_total", n_acc - a0, 3);

      // silent slave: abort after TMO ACCESS cycles
      issue(mkcmd(1'b0, 8'h90, 32'h0, 4'h0, 1'b1), mkbeh(100, 1'b0, 32'h12121212), mkrsp(2'b10, 32'h0));
      pen = 0;
      for (int unsigned i = 0; i < 60 && expq.size() != 0; i++) begin
         tick();
         if (penable) pen++;
      end
      chk("t5_timeout_cycles", pen, TMO);
      drain(10);

      for (int unsigned i = 0; i < 8; i++) issue(tbl[i].c, tbl[i].b, tbl[i].e);
      drain(400);

      rr_mode = 2;
      vprob   = 60;
      for (int unsigned i = 0; i < 80; i++) begin
         int unsigned r;
         c = mkcmd(1'($urandom()), 8'($urandom()), $urandom(), 4'($urandom()), 1'($urandom()));
         r = $urandom_range(0, 19);
         if (r < 12)      b.waits = $urandom_range(0, 2);
         else if (r < 17) b.waits = $urandom_range(3, 6);
         else if (r == 17) b.waits = TMO - 1;
         else if (r == 18) b.waits = TMO;
         else             b.waits = $urandom_range(TMO + 1, TMO + 4);
         b.err   = ($urandom_range(0, 3) == 0);
         b.rdata = $urandom();
         issue(c, b, model(c, b));
      end
      drain(30000);
      rr_mode = 0;
      vprob   = 100;

      // reset in the middle of a stalled read abandons it and the queued response
      rr_mode = 1;
      issue(mkcmd(1'b1, 8'hA0, 32'hC0FFEE00, 4'hF, 1'b0), mkbeh(0, 1'b0, 32'h0), mkrsp(2'b00, 32'h0));
      issue(mkcmd(1'b0, 8'hA4, 32'h0, 4'h0, 1'b1), mkbeh(50, 1'b0, 32'h3), mkrsp(2'b00, 32'h3));
      for (int unsigned i = 0; i < 20 && !(penable && !pwrite); i++) tick();
      chk("t6_pre_cmd_ready", cmd_ready, 1'b0);
      chk("t6_pre_rsp_valid", rsp_valid, 1'b1);
      rst = 1'b1;
      tick();
      chk("t6_psel", psel, 2'b00);
      chk("t6_penable", penable, 1'b0);
      chk("t6_paddr", paddr, 8'h0);
      chk("t6_pwdata", pwdata, 32'h0);
      chk("t6_rsp_valid", rsp_valid, 1'b0);
      chk("t6_cmd_ready", cmd_ready, 1'b1);
      rst = 1'b0;
      cmdq.delete(); behq.delete(); slvq.delete(); apbq.delete(); expq.delete();
      prev_acc = 0; prev_setup = 0;
      rr_mode  = 0;
      issue(mkcmd(1'b0, 8'h3C, 32'h0, 4'h0, 1'b0), mkbeh(1, 1'b0, 32'h600DF00D), mkrsp(2'b00, 32'h600DF00D));
      drain(20);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
